// File: rtl/muldiv_if.sv
// Request/response bundle for the multiply/divide unit: valid/ready on the op side and on the result side.
interface muldiv_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (output in_valid, op, a, b, out_ready,
                  input  in_ready, out_valid, result);
  modport slave  (input  in_valid, op, a, b, out_ready,
                  output in_ready, out_valid, result);
endinterface

// File: rtl/muldiv.sv
// Iterative RV32M/RV64M multiply/divide: latency XLEN+2 edges (1 for div special cases), result held while out_ready=0.
// MULDIV_FAST_MUL_EN: registers a combinational multiply at acceptance so MUL* ops complete in 1 edge.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  muldiv_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, state_nxt;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   res_q;

  logic              accept;
  logic              sgn_a, sgn_b, neg_in;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   spec_res;
  logic              fast_hit;
  logic [XLEN-1:0]   fast_res;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step, div_step, acc_neg;
  logic [XLEN:0]     div_shift, div_diff;
  logic [XLEN-1:0]   quo, rem, fix_res;

  assign accept = bus.in_valid & bus.in_ready;

  // Operand conditioning at acceptance: magnitudes plus a single result-sign flag.
  always_comb begin
    sgn_a    = bus.a[XLEN-1] & (bus.op == 3'b001 || bus.op == 3'b010 ||
                                bus.op == 3'b100 || bus.op == 3'b110);
    sgn_b    = bus.b[XLEN-1] & (bus.op == 3'b001 || bus.op == 3'b100 || bus.op == 3'b110);
    mag_a    = sgn_a ? (XLEN'(0) - bus.a) : bus.a;
    mag_b    = sgn_b ? (XLEN'(0) - bus.b) : bus.b;
    neg_in   = (bus.op == 3'b110) ? sgn_a : (sgn_a ^ sgn_b);
    div_zero = bus.op[2] & (bus.b == '0);
    div_ovf  = bus.op[2] & ~bus.op[0] & (bus.a == MIN_NEG) & (bus.b == '1);
    special  = div_zero | div_ovf;
    spec_res = div_zero ? (bus.op[1] ? bus.a : '1) : (bus.op[1] ? '0 : bus.a);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  always_comb begin
    fast_a    = {{XLEN{bus.a[XLEN-1] & (bus.op == 3'b001 || bus.op == 3'b010)}}, bus.a};
    fast_b    = {{XLEN{bus.b[XLEN-1] & (bus.op == 3'b001)}}, bus.b};
    fast_prod = fast_a * fast_b;
    fast_hit  = ~bus.op[2];
    fast_res  = (bus.op == 3'b000) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`else
  assign fast_hit = 1'b0;
  assign fast_res = '0;
`endif

  // One iteration step for each datapath; the same 2*XLEN register holds product or {rem, quo}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_step  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    div_step  = {div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0],
                 acc_q[XLEN-2:0], ~div_diff[XLEN]};
    acc_neg   = neg_q ? (2*XLEN)'(0) - acc_q : acc_q;
    quo       = neg_q ? XLEN'(0) - acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem       = neg_q ? XLEN'(0) - acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (op_q[2])
      fix_res = op_q[1] ? rem : quo;
    else
      fix_res = (op_q[1:0] == 2'b00) ? acc_neg[XLEN-1:0] : acc_neg[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.result    = (state == DONE) ? res_q : '0;
    case (state)
      IDLE: if (accept) state_nxt = (special | fast_hit) ? DONE : CALC;
      CALC: if (cnt_q == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Datapath registers follow the state only; flush merely abandons whatever they hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      neg_q  <= 1'b0;
      opnd_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q   <= bus.op;
          neg_q  <= neg_in;
          opnd_q <= bus.op[2] ? mag_b : mag_a;
          acc_q  <= {{XLEN{1'b0}}, bus.op[2] ? mag_a : mag_b};
          cnt_q  <= CNT_W'(XLEN - 1);
          res_q  <= special ? spec_res : fast_res;
        end
        CALC: begin
          acc_q <= op_q[2] ? div_step : mul_step;
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        end
        FIX:  res_q <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (XLEN=32): arithmetic, special cases, back-pressure, flush and reset.
module tb_muldiv_unit;
  localparam int XLEN = 32;
  localparam int IT   = XLEN + 2;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 2;
`endif

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   total = 0;
  int   bad = 0;

  muldiv_if #(.XLEN(XLEN)) bus();
  muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE; lat counts edges from the accept edge (inclusive) until out_valid.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      step();
      lat++;
    end
    res = bus.result;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    #2;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 32'h0) begin
      bad++;
      $display("FAIL reset_async: in_ready=%b out_valid=%b result=%h want 1 0 0",
               bus.in_ready, bus.out_valid, bus.result);
    end
    step(); step();
    rst = 1'b0;
    step();
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 32'h0) begin
      bad++;
      $display("FAIL reset_idle: in_ready=%b out_valid=%b result=%h want 1 0 0",
               bus.in_ready, bus.out_valid, bus.result);
    end
  endtask

  task automatic test_div();
    vec_t tbl[10] = '{
      '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, IT},
      '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, IT},
      '{3'b101, 32'd100,      32'd7,        32'd14,       IT},
      '{3'b111, 32'd100,      32'd7,        32'd2,        IT},
      '{3'b100, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, IT},
      '{3'b110, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, IT},
      '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, IT},
      '{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        IT},
      '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        IT},
      '{3'b111, 32'hFFFFFFF0, 32'd16,       32'd0,        IT}};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, res, lat);
      total++;
      if (res !== tbl[i].exp || lat != tbl[i].lat) begin
        bad++;
        $display("FAIL div[%0d] op=%b a=%h b=%h: got %h lat %0d, want %h lat %0d",
                 i, tbl[i].op, tbl[i].a, tbl[i].b, res, lat, tbl[i].exp, tbl[i].lat);
      end
      consume();
      total++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL div_consume[%0d]: in_ready=%b out_valid=%b want 1 0", i, bus.in_ready, bus.out_valid);
      end
    end
  endtask

  task automatic test_special();
    vec_t tbl[6] = '{
      '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1},
      '{3'b111, 32'd5,        32'd0,        32'd5,        1},
      '{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1},
      '{3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1},
      '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
      '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1}};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, res, lat);
      total++;
      if (res !== tbl[i].exp || lat != tbl[i].lat) begin
        bad++;
        $display("FAIL special[%0d] op=%b a=%h b=%h: got %h lat %0d, want %h lat %0d",
                 i, tbl[i].op, tbl[i].a, tbl[i].b, res, lat, tbl[i].exp, tbl[i].lat);
      end
      consume();
    end
  endtask

  task automatic test_mul();
    vec_t tbl[10] = '{
      '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT},
      '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT},
      '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT},
      '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, MUL_LAT},
      '{3'b000, 32'd12345,    32'd6789,     32'd83810205, MUL_LAT},
      '{3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, MUL_LAT},
      '{3'b001, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, MUL_LAT},
      '{3'b011, 32'hFFFFFFFD, 32'd5,        32'd4,        MUL_LAT},
      '{3'b010, 32'd5,        32'hFFFFFFFD, 32'd4,        MUL_LAT},
      '{3'b010, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, MUL_LAT}};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, res, lat);
      total++;
      if (res !== tbl[i].exp || lat != tbl[i].lat) begin
        bad++;
        $display("FAIL mul[%0d] op=%b a=%h b=%h: got %h lat %0d, want %h lat %0d",
                 i, tbl[i].op, tbl[i].a, tbl[i].b, res, lat, tbl[i].exp, tbl[i].lat);
      end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int lat;
    run_op(3'b101, 32'd100, 32'd7, res, lat);
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (bus.out_valid !== 1'b1 || bus.result !== 32'd14 || bus.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold[%0d]: out_valid=%b result=%h in_ready=%b want 1 0000000e 0",
                 i, bus.out_valid, bus.result, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.op = 3'b101; bus.a = 32'd9; bus.b = 32'd0;
    step();
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL consume_no_accept: out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'hFFFFFFFF) begin
      bad++;
      $display("FAIL accept_after_consume: out_valid=%b result=%h want 1 ffffffff", bus.out_valid, bus.result);
    end
    consume();
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int lat;
    int seen;
    bus.op = 3'b101; bus.a = 32'd1000; bus.b = 32'd3; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_calc: in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.out_valid === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL flush_no_result: out_valid high on %0d cycles, want 0", seen);
    end
    run_op(3'b101, 32'd100, 32'd7, res, lat);
    total++;
    if (res !== 32'd14 || lat != IT) begin
      bad++;
      $display("FAIL after_flush: got %h lat %0d, want 0000000e lat %0d", res, lat, IT);
    end
    // Flush wins over a simultaneous consume while DONE.
    bus.out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_done: out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int lat;
    bus.op = 3'b100; bus.a = 32'd77; bus.b = 32'd5; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b result=%h want 1 0 0",
               bus.in_ready, bus.out_valid, bus.result);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) step();
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_no_result: out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    run_op(3'b111, 32'd100, 32'd7, res, lat);
    total++;
    if (res !== 32'd2 || lat != IT) begin
      bad++;
      $display("FAIL after_reset: got %h lat %0d, want 00000002 lat %0d", res, lat, IT);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_div();
    test_special();
    test_mul();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
